sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one `sram` controller between two requesters: port 0 (pattern writer) and port 1 (readback/display).
- Round-robin arbitration; one SRAM access in flight at a time.
- Owns the controller's command interface: `address`, `data_write`, `read`, `write`, `ready`, `data_read`.
- Sits between the top level and the `sram` instance, replacing direct `read`/`write` driving from the top level.

Parameters:
- ADDR_W, 18, address width (matches the SRAM `ADR` pins).
- DATA_W, 16, data width (matches the SRAM `DAT` pins).
- TIMEOUT, 255, max cycles to wait on each `ready` edge before aborting the access; minimum 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req0, req1  in  1 each  access request; held until the matching ack.
- we0, we1  in  1 each  1=write, 0=read; held with req.
- addr0, addr1  in  ADDR_W each  access address; held with req.
- wdata0, wdata1  in  DATA_W each  write data; held with req.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = access timed out.
- rdata  out  DATA_W  read data; valid with ack, held until the next ack.
- busy  out  1  high whenever state != IDLE.
- sram_address  out  ADDR_W  to controller `address`.
- sram_data_write  out  DATA_W  to controller `data_write`.
- sram_read, sram_write  out  1 each  to controller `read` / `write`.
- sram_ready  in  1  from controller `ready`.
- sram_data_read  in  DATA_W  from controller `data_read`.

Behaviour:
- **Registered outputs.** All outputs are registered. On reset assertion every output clears to 0 immediately. Internally: state=IDLE, last=1 (port 0 wins first), timer=0.
- **Controller contract.**
  - A command is a 1-cycle `sram_read`/`sram_write` pulse, issued only while `sram_ready`=1.
  - The controller drops `ready`, then raises it again on completion.
  - `sram_data_read` is valid while `ready`=1 after a read.
- **IDLE.**
  - Acts only when `sram_ready`=1 and (req0 or req1) at the edge.
  - Winner: the sole requester, or if both request, the port != last.
  - Latches winner addr/wdata into `sram_address`/`sram_data_write`, sets `sram_write` (we=1) or `sram_read` (we=0), records the owner, sets last=owner, then goes to ISSUE.
  - If `sram_ready`=0, it waits with no command issued.
- **ISSUE (exactly 1 cycle).** Clears `sram_read`/`sram_write`, timer=0, then goes to WAIT_LOW.
- **WAIT_LOW.**
  - `sram_ready`=0 sampled → timer=0, go to WAIT_HIGH.
  - Otherwise timer+1; at timer==TIMEOUT → ACK with err=1.
- **WAIT_HIGH.**
  - `sram_ready`=1 sampled → rdata<=`sram_data_read` (reads only; rdata unchanged on writes), err=0, go to ACK.
  - Otherwise timer+1; at timer==TIMEOUT → ACK with err=1, rdata unchanged.
- **ACK (exactly 1 cycle).** The owner's ack=1; the other ack stays 0. Next state is IDLE; ack and err clear.
- **ACK spacing.** ACK is followed by at least one IDLE sampling edge. A requester that drops req on the edge it sees ack is never re-granted.
- **Latency.** Request sampled at edge k → command pulse during cycle k+1 → ack no earlier than 4 cycles after k (with a 1-cycle controller).
- **Address/data stability.** `sram_address`/`sram_data_write` hold from issue until the next grant; they are never changed mid-access.
- **Request changes mid-access.** Changes on either port's inputs during ISSUE through ACK are ignored. A new req on the non-owner is served after ACK.
- **Starvation bound.** If both requesters hold req continuously, grants strictly alternate.
- **Reset mid-access.** Async reset aborts the access: no ack is issued and the command pulse is dropped. After release, arbitration restarts with port 0 first.
- **Timer width.** The timer is clog2(TIMEOUT+1) bits and never wraps; it is cleared on every state entry that uses it.

Test Plan:
- **Single write.** Reset low for 3 cycles, release. req0=1, we0=1, addr0=18'h00010, wdata0=16'hAAAA; controller model with a 2-cycle busy → exactly one `sram_write` pulse with `sram_address`=16'h10, `sram_data_write`=16'hAAAA; one ack0 pulse with err=0; ack1 never asserts.
- **Read.** req1 read addr1=18'h00010, model returns 16'hAAAA → one `sram_read` pulse; ack1 with rdata=16'hAAAA; rdata still 16'hAAAA 10 cycles later.
- **Round robin.** req0 and req1 both held high for 6 accesses, starting after reset → grant order 0,1,0,1,0,1. Never two commands without an intervening ready low→high.
- **Ready held low.** Force `sram_ready`=0 while req0=1 for 50 cycles → no command issued, busy=0; after ready=1, the command is issued within 1 cycle.
- **Timeout.** TIMEOUT=8, model never drops ready after a read command → ack0 with err=1 exactly 9 cycles after ISSUE, rdata unchanged; the next request is served normally.
- **Reset mid-access.** Assert reset during WAIT_HIGH → all outputs 0 immediately, no ack. After release with both req high, port 0 is granted first.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one SRAM controller between two requesters.
// One access in flight at a time; every access is bounded by a ready-edge timeout.
module sram_arbiter #(
   parameter int unsigned ADDR_W  = 18,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_address,
   output logic [DATA_W-1:0] sram_data_write,
   output logic              sram_read,
   output logic              sram_write,
   input  logic              sram_ready,
   input  logic [DATA_W-1:0] sram_data_read
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_LOW  = 3'd2,
      S_WAIT_HIGH = 3'd3,
      S_ACK       = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_last;
   logic               r_owner;
   logic               r_we;
   logic [TMR_W-1:0]   r_timer;

   logic               w_grant;
   logic               w_winner;
   logic [TMR_W-1:0]   w_timer_inc;
   logic               w_timeout;

   logic               w_last_nxt;
   logic               w_owner_nxt;
   logic               w_we_nxt;
   logic [TMR_W-1:0]   w_timer_nxt;
   logic               w_ack0_nxt;
   logic               w_ack1_nxt;
   logic               w_err_nxt;
   logic [DATA_W-1:0]  w_rdata_nxt;
   logic               w_busy_nxt;
   logic [ADDR_W-1:0]  w_address_nxt;
   logic [DATA_W-1:0]  w_data_write_nxt;
   logic               w_read_nxt;
   logic               w_write_nxt;

   // Arbitration: sole requester wins, a tie goes to the port that was not served last
   assign w_grant     = sram_ready & (req0 | req1);
   assign w_winner    = (req0 & req1) ? ~r_last : req1;
   assign w_timer_inc = r_timer + TMR_W'(1);
   assign w_timeout   = (w_timer_inc == TMR_W'(TIMEOUT));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:      if (w_grant) w_state_nxt = S_ISSUE;
         S_ISSUE:     w_state_nxt = S_WAIT_LOW;
         S_WAIT_LOW:  if (!sram_ready) w_state_nxt = S_WAIT_HIGH;
                      else if (w_timeout) w_state_nxt = S_ACK;
         S_WAIT_HIGH: if (sram_ready || w_timeout) w_state_nxt = S_ACK;
         S_ACK:       w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and access bookkeeping
   always_comb begin
      w_last_nxt       = r_last;
      w_owner_nxt      = r_owner;
      w_we_nxt         = r_we;
      w_timer_nxt      = r_timer;
      w_ack0_nxt       = 1'b0;
      w_ack1_nxt       = 1'b0;
      w_err_nxt        = 1'b0;
      w_rdata_nxt      = rdata;
      w_address_nxt    = sram_address;
      w_data_write_nxt = sram_data_write;
      w_read_nxt       = 1'b0;
      w_write_nxt      = 1'b0;
      w_busy_nxt       = (w_state_nxt != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               w_owner_nxt      = w_winner;
               w_last_nxt       = w_winner;
               w_we_nxt         = w_winner ? we1 : we0;
               w_address_nxt    = w_winner ? addr1 : addr0;
               w_data_write_nxt = w_winner ? wdata1 : wdata0;
               w_write_nxt      = w_winner ? we1 : we0;
               w_read_nxt       = ~(w_winner ? we1 : we0);
            end
         end
         S_ISSUE: w_timer_nxt = '0;
         S_WAIT_LOW: begin
            if (!sram_ready) begin
               w_timer_nxt = '0;
            end else if (w_timeout) begin
               w_ack0_nxt = ~r_owner;
               w_ack1_nxt = r_owner;
               w_err_nxt  = 1'b1;
            end else begin
               w_timer_nxt = w_timer_inc;
            end
         end
         S_WAIT_HIGH: begin
            if (sram_ready) begin
               if (!r_we) w_rdata_nxt = sram_data_read;
               w_ack0_nxt = ~r_owner;
               w_ack1_nxt = r_owner;
            end else if (w_timeout) begin
               w_ack0_nxt = ~r_owner;
               w_ack1_nxt = r_owner;
               w_err_nxt  = 1'b1;
            end else begin
               w_timer_nxt = w_timer_inc;
            end
         end
         default: ;
      endcase
   end

   // Output and bookkeeping registers; reset drops any command and ack in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last          <= 1'b1;
         r_owner         <= 1'b0;
         r_we            <= 1'b0;
         r_timer         <= '0;
         ack0            <= 1'b0;
         ack1            <= 1'b0;
         err             <= 1'b0;
         rdata           <= '0;
         busy            <= 1'b0;
         sram_address    <= '0;
         sram_data_write <= '0;
         sram_read       <= 1'b0;
         sram_write      <= 1'b0;
      end else begin
         r_last          <= w_last_nxt;
         r_owner         <= w_owner_nxt;
         r_we            <= w_we_nxt;
         r_timer         <= w_timer_nxt;
         ack0            <= w_ack0_nxt;
         ack1            <= w_ack1_nxt;
         err             <= w_err_nxt;
         rdata           <= w_rdata_nxt;
         busy            <= w_busy_nxt;
         sram_address    <= w_address_nxt;
         sram_data_write <= w_data_write_nxt;
         sram_read       <= w_read_nxt;
         sram_write      <= w_write_nxt;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios plus a randomized two-requester run against a
// request-level reference model and a behavioural SRAM controller.
module tb_sram_arbiter;

   localparam int unsigned AW = 18;
   localparam int unsigned DW = 16;
   localparam int unsigned TO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          ack0, ack1, err, busy, sram_read, sram_write;
   logic [DW-1:0] rdata, sram_data_write;
   logic [AW-1:0] sram_address;
   logic          sram_ready = 1'b1;
   logic [DW-1:0] sram_data_read = '0;

   int n_vec = 0, n_miss = 0;
   int cyc = 0;

   sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy),
      .sram_address(sram_address), .sram_data_write(sram_data_write),
      .sram_read(sram_read), .sram_write(sram_write),
      .sram_ready(sram_ready), .sram_data_read(sram_data_read)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Behavioural controller: drops ready for busy_cycles after a command, then raises it
   int            n_wr = 0, n_rd = 0, n_ack0 = 0, n_ack1 = 0;
   logic [AW-1:0] last_cmd_addr = '0;
   logic [DW-1:0] last_cmd_data = '0;
   bit            c_pending = 0, c_we = 0;
   int            c_cnt = 0;
   logic [AW-1:0] c_addr = '0;
   int            busy_cycles = 2;
   bit            force_low = 0, stuck_high = 0;
   logic [DW-1:0] ctl_mem [logic [AW-1:0]];

   always @(negedge clk) begin
      if (ack0) n_ack0++;
      if (ack1) n_ack1++;
      if (!reset) begin
         c_pending  = 0;
         c_cnt      = 0;
         sram_ready = !force_low;
      end else begin
         if (sram_read || sram_write) begin
            if (sram_write) n_wr++; else n_rd++;
            last_cmd_addr = sram_address;
            last_cmd_data = sram_data_write;
            check("cmd_while_ready", 32'(sram_ready), 32'd1);
            check("cmd_no_overlap", 32'(c_pending), 32'd0);
            if (!stuck_high) begin
               c_pending = 1;
               c_cnt     = busy_cycles;
               c_addr    = sram_address;
               c_we      = sram_write;
               if (sram_write) ctl_mem[sram_address] = sram_data_write;
            end
         end else if (c_pending) begin
            c_cnt--;
            if (c_cnt == 0) begin
               c_pending = 0;
               if (!c_we) sram_data_read = ctl_mem.exists(c_addr) ? ctl_mem[c_addr] : '0;
            end
         end
         sram_ready = !force_low && !c_pending;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input bit r, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      if (p == 0) begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
      else        begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
   endtask

   task automatic wait_ack(input int p, input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if ((p == 0 && ack0) || (p == 1 && ack1)) begin ok = 1; break; end
      end
   endtask

   task automatic wait_cmd(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (sram_read || sram_write) begin ok = 1; break; end
      end
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_ack0"}, 32'(ack0), 32'd0);
      check({pfx, "_ack1"}, 32'(ack1), 32'd0);
      check({pfx, "_err"}, 32'(err), 32'd0);
      check({pfx, "_rdata"}, 32'(rdata), 32'd0);
      check({pfx, "_busy"}, 32'(busy), 32'd0);
      check({pfx, "_read"}, 32'(sram_read), 32'd0);
      check({pfx, "_write"}, 32'(sram_write), 32'd0);
      check({pfx, "_addr"}, 32'(sram_address), 32'd0);
      check({pfx, "_wdata"}, 32'(sram_data_write), 32'd0);
   endtask

   // Reference-model state for the randomized phase
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   bit            act [2];
   int            cool [2];
   bit            rq_we [2];
   logic [AW-1:0] rq_addr [2];
   logic [DW-1:0] rq_data [2];
   bit            prev_req [2];

   initial begin
      bit ok;
      int base_a, base_b, base_c, c0, c1, p, last, own;
      bit own_valid;
      int order [$];
      logic [DW-1:0] exp_rd;

      // Reset held for 3 cycles
      repeat (3) @(posedge clk);
      tick();
      check_zero("reset");
      reset = 1'b1;

      // Single write from port 0
      base_a = n_wr; base_b = n_ack1; base_c = n_rd;
      tick();
      set_req(0, 1, 1, 18'h00010, 16'hAAAA);
      wait_ack(0, 50, ok);
      check("wr_ack0_seen", 32'(ok), 32'd1);
      check("wr_err", 32'(err), 32'd0);
      check("wr_ack1_quiet", 32'(ack1), 32'd0);
      set_req(0, 0, 0, '0, '0);
      repeat (3) tick();
      check("wr_pulses", 32'(n_wr - base_a), 32'd1);
      check("wr_no_reads", 32'(n_rd - base_c), 32'd0);
      check("wr_addr", 32'(last_cmd_addr), 32'h10);
      check("wr_data", 32'(last_cmd_data), 32'hAAAA);
      check("wr_no_ack1", 32'(n_ack1 - base_b), 32'd0);

      // Readback from port 1
      base_a = n_rd;
      set_req(1, 1, 0, 18'h00010, '0);
      wait_ack(1, 50, ok);
      check("rd_ack1_seen", 32'(ok), 32'd1);
      check("rd_err", 32'(err), 32'd0);
      check("rd_data", 32'(rdata), 32'hAAAA);
      set_req(1, 0, 0, '0, '0);
      repeat (10) tick();
      check("rd_data_held", 32'(rdata), 32'hAAAA);
      check("rd_pulses", 32'(n_rd - base_a), 32'd1);

      // Round robin with both requests held from reset
      reset = 1'b0; tick(); reset = 1'b1;
      set_req(0, 1, 1, 18'h00020, 16'h1111);
      set_req(1, 1, 1, 18'h00021, 16'h2222);
      for (int i = 0; i < 300 && order.size() < 6; i++) begin
         tick();
         if (ack0) order.push_back(0);
         if (ack1) order.push_back(1);
      end
      set_req(0, 0, 0, '0, '0);
      set_req(1, 0, 0, '0, '0);
      check("rr_count", 32'(order.size()), 32'd6);
      for (int i = 0; i < 6 && i < order.size(); i++)
         check($sformatf("rr_grant%0d", i), 32'(order[i]), 32'(i % 2));
      repeat (3) tick();

      // Ready forced low: nothing issues until it rises
      force_low = 1; tick();
      base_a = n_rd + n_wr;
      set_req(0, 1, 0, 18'h00020, '0);
      repeat (50) tick();
      check("rl_no_cmd", 32'(n_rd + n_wr - base_a), 32'd0);
      check("rl_busy", 32'(busy), 32'd0);
      force_low = 0;
      ok = 0;
      for (int i = 0; i < 5 && !ok; i++) begin tick(); ok = sram_ready; end
      check("rl_ready_back", 32'(ok), 32'd1);
      tick();
      check("rl_cmd_next", 32'(sram_read), 32'd1);
      wait_ack(0, 50, ok);
      check("rl_ack0", 32'(ok), 32'd1);
      check("rl_rdata", 32'(rdata), 32'h1111);
      set_req(0, 0, 0, '0, '0);
      repeat (2) tick();

      // Timeout: controller never drops ready
      stuck_high = 1;
      set_req(0, 1, 0, 18'h00021, '0);
      wait_cmd(20, ok);
      check("to_cmd", 32'(ok), 32'd1);
      c0 = cyc;
      wait_ack(0, 40, ok);
      c1 = cyc;
      check("to_ack0", 32'(ok), 32'd1);
      check("to_latency", 32'(c1 - c0), 32'(TO + 1));
      check("to_err", 32'(err), 32'd1);
      check("to_rdata_kept", 32'(rdata), 32'h1111);
      set_req(0, 0, 0, '0, '0);
      stuck_high = 0;
      tick();
      set_req(1, 1, 0, 18'h00021, '0);
      wait_ack(1, 50, ok);
      check("to_next_ack1", 32'(ok), 32'd1);
      check("to_next_err", 32'(err), 32'd0);
      check("to_next_rdata", 32'(rdata), 32'h2222);
      set_req(1, 0, 0, '0, '0);
      repeat (2) tick();

      // Reset during WAIT_HIGH
      busy_cycles = 6;
      set_req(0, 1, 0, 18'h00010, '0);
      wait_cmd(20, ok);
      check("rm_cmd", 32'(ok), 32'd1);
      repeat (3) tick();
      check("rm_busy_before", 32'(busy), 32'd1);
      base_a = n_ack0 + n_ack1;
      reset = 1'b0;
      #1;
      check_zero("rm");
      set_req(1, 1, 0, 18'h00021, '0);
      repeat (2) tick();
      check("rm_no_ack", 32'(n_ack0 + n_ack1 - base_a), 32'd0);
      reset = 1'b1;
      busy_cycles = 2;
      wait_cmd(20, ok);
      check("rm_regrant", 32'(ok), 32'd1);
      check("rm_port0_first", 32'(sram_address), 32'h10);
      wait_ack(0, 50, ok);
      check("rm_ack0", 32'(ok), 32'd1);
      check("rm_rdata", 32'(rdata), 32'hAAAA);
      set_req(0, 0, 0, '0, '0);
      wait_ack(1, 50, ok);
      check("rm_ack1", 32'(ok), 32'd1);
      set_req(1, 0, 0, '0, '0);
      repeat (2) tick();

      // Randomized two-port traffic against the request-level model
      reset = 1'b0; tick(); reset = 1'b1;
      last = 1; own = 0; own_valid = 0;
      for (int k = 0; k < 2; k++) begin act[k] = 0; cool[k] = 0; prev_req[k] = 0; end
      for (int i = 0; i < 700; i++) begin
         tick();
         busy_cycles = $urandom_range(2, 5);
         if (sram_read || sram_write) begin
            check("rnd_cmd_requested", 32'(prev_req[0] || prev_req[1]), 32'd1);
            if (prev_req[0] && prev_req[1]) p = (last == 0) ? 1 : 0;
            else                            p = prev_req[1] ? 1 : 0;
            last = p;
            check("rnd_cmd_addr", 32'(sram_address), 32'(rq_addr[p]));
            check("rnd_cmd_we", 32'(sram_write), 32'(rq_we[p]));
            if (rq_we[p]) check("rnd_cmd_data", 32'(sram_data_write), 32'(rq_data[p]));
            own = p; own_valid = 1;
         end
         if (ack0 || ack1) begin
            check("rnd_ack_owned", 32'(own_valid), 32'd1);
            check("rnd_ack_port", 32'({ack1, ack0}), (own == 1) ? 32'd2 : 32'd1);
            check("rnd_err", 32'(err), 32'd0);
            if (rq_we[own]) begin
               ref_mem[rq_addr[own]] = rq_data[own];
            end else begin
               exp_rd = ref_mem.exists(rq_addr[own]) ? ref_mem[rq_addr[own]] : '0;
               check("rnd_rdata", 32'(rdata), 32'(exp_rd));
            end
            act[own] = 0;
            cool[own] = $urandom_range(1, 3);
            set_req(own, 0, 0, '0, '0);
            own_valid = 0;
         end
         for (int k = 0; k < 2; k++) begin
            if (!act[k]) begin
               if (cool[k] > 0) cool[k]--;
               else if (i < 640 && $urandom_range(0, 2) == 0) begin
                  act[k]     = 1;
                  rq_we[k]   = 1'($urandom_range(0, 1));
                  rq_addr[k] = AW'(18'h00100 + 18'($urandom_range(0, 7)));
                  rq_data[k] = DW'($urandom);
                  set_req(k, 1, rq_we[k], rq_addr[k], rq_data[k]);
               end
            end
         end
         prev_req[0] = req0;
         prev_req[1] = req1;
      end
      check("rnd_all_served", 32'(act[0] || act[1]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
